uart_tx: RTL and testbench

Byte-to-serial UART transmitter, the transmit-side counterpart of the design's UART receiver. It runs on the same baud-multiplied UART clock and drives an 8N1 frame (8E1 when parity is compiled in), LSB first, on the TX line. A one-byte holding register lets the user queue the next byte while the current frame is shifting, so consecutive frames go out back-to-back with no idle gap.

---
 rtl/uart_tx.sv | 179 +++++++++++++++++
 tb/tb_uart_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx - byte-to-serial UART transmitter (8N1, or 8E1 with parity).
//
// Sends one frame per accepted byte on the TX line, LSB first. A one-byte
// holding register accepts the next byte while the current frame shifts, so
// queued frames go out back-to-back with no idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   - one even-parity bit between D7 and stop (11-bit frame)
//   undefined - plain 8N1 (10-bit frame)
//
// Parameters:
//   BAUD_MULT   clock cycles per bit (>= 2)
// Ports:
//   i_uart_clk  clock for the whole block
//   i_reset     synchronous active-high reset
//   i_tx_byte   byte to send, sampled on handshake
//   i_tx_valid  user offers i_tx_byte
//   o_tx_ready  block can accept a byte this cycle (handshake = valid && ready)
//   o_tx        registered serial line, idle high
//   o_tx_busy   a frame is on the line
module uart_tx #(
    parameter int BAUD_MULT = 139
) (
    input  logic       i_uart_clk,
    input  logic       i_reset,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx,
    output logic       o_tx_busy
);

    localparam int              CW       = $clog2(BAUD_MULT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(BAUD_MULT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    // Shift register is destroyed while sending, so parity is captured at load.
    logic          par_q, par_d;
`endif

    logic hs;
    logic bit_end;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        hs      = i_tx_valid && !hold_full_q;
        bit_end = (cnt_q == CNT_LAST);
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (hs) begin
                    shift_d = i_tx_byte;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^i_tx_byte;
`endif
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
`ifdef UART_TX_PARITY_EN
                        par_d       = ^hold_q;
`endif
                        hold_full_d = 1'b0;
                        state_d     = S_START;
                    end else if (hs) begin
                        // Late handshake on the final stop cycle bypasses the hold.
                        shift_d = i_tx_byte;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^i_tx_byte;
`endif
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Mid-frame handshake parks the byte in the holding register.
        if (hs && (state_q != S_IDLE) && !((state_q == S_STOP) && bit_end)) begin
            hold_d      = i_tx_byte;
            hold_full_d = 1'b1;
        end

        // Line value is registered from the next state so it changes with it.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_uart_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign o_tx       = tx_q;
    assign o_tx_busy  = (state_q != S_IDLE);
    assign o_tx_ready = !hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx at BAUD_MULT = 4. A queue-based line model predicts
// o_tx / o_tx_busy / o_tx_ready every cycle; directed tests add literal
// expectations (mid-bit samples, busy and ready-low cycle counts).
module tb_uart_tx;

    localparam int B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FR = NB * B;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_tx_byte;
    logic       i_tx_valid;
    logic       o_tx_ready, o_tx, o_tx_busy;

    uart_tx #(.BAUD_MULT(B)) dut (
        .i_uart_clk (clk),
        .i_reset    (i_reset),
        .i_tx_byte  (i_tx_byte),
        .i_tx_valid (i_tx_valid),
        .o_tx_ready (o_tx_ready),
        .o_tx       (o_tx),
        .o_tx_busy  (o_tx_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- line model ----------------
    // line: expected o_tx for each upcoming cycle of queued frames.
    // pend: accepted bytes not yet started.
    logic       line[$];
    logic [7:0] pend[$];
    bit         model_on = 0;

    always @(posedge clk) begin
        logic       hs;
        logic [7:0] b;
        logic [10:0] frm;
        if (i_reset) begin
            line.delete();
            pend.delete();
            model_on = 1;
        end else if (model_on) begin
            hs = i_tx_valid && (pend.size() == 0);
            if (line.size() != 0) void'(line.pop_front());
            if (hs) pend.push_back(i_tx_byte);
            if (line.size() == 0 && pend.size() != 0) begin
                b = pend.pop_front();
`ifdef UART_TX_PARITY_EN
                frm = {1'b1, ^b, b, 1'b0};
`else
                frm = {1'b0, 1'b1, b, 1'b0};
`endif
                for (int i = 0; i < NB; i++)
                    for (int r = 0; r < B; r++) line.push_back(frm[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("tx",    int'(o_tx),       (line.size() != 0) ? int'(line[0]) : 1);
            check("busy",  int'(o_tx_busy),  (line.size() != 0) ? 1 : 0);
            check("ready", int'(o_tx_ready), (pend.size() == 0) ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    // Optionally hands b0 over at the edge before cycle 1, then runs n cycles,
    // offering b1 during cycle hs_k. bits[j] = o_tx mid-bit j.
    task automatic collect(input bit send0, input logic [7:0] b0,
                           input int hs_k, input logic [7:0] b1, input int n,
                           output int busy_n, output int rdy_lo, output int tx_lo,
                           output logic [21:0] bits);
        busy_n = 0; rdy_lo = 0; tx_lo = 0; bits = '0;
        if (send0) begin
            @(negedge clk);
            i_tx_valid = 1'b1;
            i_tx_byte  = b0;
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            i_tx_valid = (k == hs_k);
            i_tx_byte  = (k == hs_k) ? b1 : 8'h00;
            busy_n += int'(o_tx_busy);
            rdy_lo += int'(!o_tx_ready);
            tx_lo  += int'(!o_tx);
            if (((k - 1) % B == 1) && ((k - 1) / B < 22)) bits[(k - 1) / B] = o_tx;
        end
        i_tx_valid = 1'b0;
    endtask

    int          bn, rl, tl;
    logic [21:0] bits;

    initial begin
        i_reset = 1'b1; i_tx_valid = 1'b0; i_tx_byte = 8'h00;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;

        // Idle after reset.
        collect(0, 8'h00, 0, 8'h00, 20, bn, rl, tl, bits);
        check("idle_busy", bn, 0);
        check("idle_rdylo", rl, 0);
        check("idle_txlo", tl, 0);

        // Single frame 0xA5.
        collect(1, 8'hA5, 0, 8'h00, FR + 4, bn, rl, tl, bits);
        check("a5_busy", bn, FR);
        check("a5_rdylo", rl, 0);
`ifdef UART_TX_PARITY_EN
        check("a5_bits", int'(bits[10:0]), 11'h54A);
`else
        check("a5_bits", int'(bits[9:0]), 10'h34A);
`endif

        // 0x3C then 0xFF queued during the first frame.
        collect(1, 8'h3C, 5, 8'hFF, 2 * FR + 4, bn, rl, tl, bits);
        check("q_busy", bn, 2 * FR);
`ifdef UART_TX_PARITY_EN
        check("q_rdylo", rl, 39);
        check("q_bits", int'(bits), {11'h5FE, 11'h478});
`else
        check("q_rdylo", rl, 35);
        check("q_bits", int'(bits[19:0]), {10'h3FE, 10'h278});
`endif

        // 0x00 handed over on the last stop-bit cycle with the hold empty.
        collect(1, 8'h00, FR, 8'h00, 2 * FR + 4, bn, rl, tl, bits);
        check("late_busy", bn, 2 * FR);
        check("late_rdylo", rl, 0);
`ifdef UART_TX_PARITY_EN
        check("late_bits", int'(bits), {11'h400, 11'h400});
`else
        check("late_bits", int'(bits[19:0]), {10'h200, 10'h200});
`endif

        // Reset during D3 of 0x55 with 0x99 queued.
        @(negedge clk);
        i_tx_valid = 1'b1; i_tx_byte = 8'h55;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            i_tx_valid = (k == 3);
            i_tx_byte  = (k == 3) ? 8'h99 : 8'h00;
            i_reset    = (k == 18);
            if (k == 17) check("rst_pre_rdy", int'(o_tx_ready), 0);
            if (k == 19) begin
                check("rst_tx", int'(o_tx), 1);
                check("rst_busy", int'(o_tx_busy), 0);
                check("rst_rdy", int'(o_tx_ready), 1);
            end
        end
        collect(0, 8'h00, 0, 8'h00, 2 * FR, bn, rl, tl, bits);
        check("rst_after_busy", bn, 0);
        check("rst_after_txlo", tl, 0);

        // Parity cases.
        collect(1, 8'h07, 0, 8'h00, FR + 4, bn, rl, tl, bits);
        check("p07_busy", bn, FR);
`ifdef UART_TX_PARITY_EN
        check("p07_bits", int'(bits[10:0]), 11'h60E);
        check("p07_len", bn, 44);
`else
        check("p07_bits", int'(bits[9:0]), 10'h20E);
`endif
        collect(1, 8'h03, 0, 8'h00, FR + 4, bn, rl, tl, bits);
`ifdef UART_TX_PARITY_EN
        check("p03_bits", int'(bits[10:0]), 11'h406);
`else
        check("p03_bits", int'(bits[9:0]), 10'h206);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
